rv_source: RTL and testbench

RV_SOURCE -- requirements
Module: rv_source

---
 rtl/rv_source_pkg.sv | 19 +
 rtl/rv_source_gap_timer.sv | 41 ++++
 rtl/rv_source.sv | 154 +++++++++++++++
 tb/tb_rv_source.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_source_pkg.sv
// Shared types for the rv_source burst generator: FSM state encoding and the
// beat record (payload plus last flag) presented on the output channel.
package rv_source_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Widest payload carried in a beat; instances narrow it to their WIDTH.
    localparam int BEAT_DATA_W = 32;

    typedef struct packed {
        logic [BEAT_DATA_W-1:0] data;
        logic                   last;
    } beat_t;

endpackage

// File: rtl/rv_source_gap_timer.sv
// Idle-gap countdown for rv_source: loads GAP after each accepted beat and
// counts down to zero; with GAP == 0 the counter is constant zero.
module rv_source_gap_timer #(
    parameter int GAP = 0
) (
    input  logic CLK,
    input  logic ASYNCRESETN,
    input  logic i_clear,
    input  logic i_load,
    output logic o_zero
);

    generate
        if (GAP == 0) begin : g_no_gap
            logic w_unused_ok;
            assign w_unused_ok = &{1'b0, CLK, ASYNCRESETN, i_clear, i_load};
            assign o_zero      = 1'b1;
        end else begin : g_gap
            localparam int GW = $clog2(GAP + 1);
            logic [GW-1:0] r_cnt;

            // Countdown register: clear wins over load, load wins over decrement.
            always_ff @(posedge CLK or negedge ASYNCRESETN) begin
                if (!ASYNCRESETN) begin
                    r_cnt <= {GW{1'b0}};
                end else if (i_clear) begin
                    r_cnt <= {GW{1'b0}};
                end else if (i_load) begin
                    r_cnt <= GW'(GAP);
                end else if (r_cnt != {GW{1'b0}}) begin
                    r_cnt <= r_cnt - GW'(1);
                end else begin
                    r_cnt <= r_cnt;
                end
            end

            assign o_zero = (r_cnt == {GW{1'b0}});
        end
    endgenerate

endmodule

// File: rtl/rv_source.sv
// Valid/ready burst source: emits length beats starting at seed, stepping by
// STEP, with GAP idle cycles per beat. Define RV_SOURCE_ASSERT_EN for protocol assertions.
module rv_source
    import rv_source_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int LEN_W = 4,
    parameter int STEP  = 1,
    parameter int GAP   = 0
) (
    input  logic             CLK,
    input  logic             ASYNCRESETN,
    input  logic             start,
    input  logic [LEN_W-1:0] length,
    input  logic [WIDTH-1:0] seed,
    input  logic             abort,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             last,
    output logic             busy,
    output logic             done,
    output logic             aborted
);

    state_e             r_state;
    logic [WIDTH-1:0]   r_data_q;
    logic [LEN_W-1:0]   r_remaining;
    logic               r_abort_q;
    logic               r_aborted;

    state_e             w_next_state;
    logic               w_next_aborted;
    logic               w_load_burst;
    logic               w_handshake;
    logic               w_valid;
    logic               w_abort_any;
    logic               w_gap_zero;
    beat_t              w_beat;
    logic               w_unused_beat;

    rv_source_gap_timer #(
        .GAP (GAP)
    ) u_gap_timer (
        .CLK         (CLK),
        .ASYNCRESETN (ASYNCRESETN),
        .i_clear     (w_load_burst),
        .i_load      (w_handshake),
        .o_zero      (w_gap_zero)
    );

    // State, payload, beat count and sticky abort latch.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            r_state     <= ST_IDLE;
            r_data_q    <= {WIDTH{1'b0}};
            r_remaining <= {LEN_W{1'b0}};
            r_abort_q   <= 1'b0;
            r_aborted   <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_aborted <= w_next_aborted;
            if (w_load_burst) begin
                r_data_q    <= seed;
                r_remaining <= length;
            end else if (w_handshake) begin
                r_data_q    <= r_data_q + WIDTH'(STEP);
                r_remaining <= r_remaining - LEN_W'(1);
            end else begin
                r_data_q    <= r_data_q;
                r_remaining <= r_remaining;
            end
            if (w_load_burst) begin
                r_abort_q <= 1'b0;
            end else if ((r_state == ST_SEND) && abort) begin
                r_abort_q <= 1'b1;
            end else begin
                r_abort_q <= r_abort_q;
            end
        end
    end

    // Next state and beat presentation; an abort seen this cycle counts as latched.
    always_comb begin
        w_next_state   = r_state;
        w_next_aborted = 1'b0;
        w_load_burst   = 1'b0;
        w_handshake    = 1'b0;
        w_valid        = 1'b0;
        w_abort_any    = r_abort_q | abort;
        w_beat.data    = BEAT_DATA_W'(r_data_q);
        w_beat.last    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (length != {LEN_W{1'b0}}) begin
                        w_next_state = ST_SEND;
                        w_load_burst = 1'b1;
                    end else begin
                        w_next_state = ST_DONE;
                    end
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_SEND: begin
                w_valid     = w_gap_zero;
                w_beat.last = w_gap_zero && (r_remaining == LEN_W'(1));
                w_handshake = w_valid && ready;
                if (w_handshake) begin
                    if (w_beat.last) begin
                        w_next_state = ST_DONE;
                    end else if (w_abort_any) begin
                        w_next_state   = ST_DONE;
                        w_next_aborted = 1'b1;
                    end else begin
                        w_next_state = ST_SEND;
                    end
                end else if (!w_valid && w_abort_any) begin
                    w_next_state   = ST_DONE;
                    w_next_aborted = 1'b1;
                end else begin
                    w_next_state = ST_SEND;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign w_unused_beat = ^w_beat.data;
    assign valid   = w_valid;
    assign data    = w_beat.data[WIDTH-1:0];
    assign last    = w_beat.last;
    assign busy    = (r_state == ST_SEND);
    assign done    = (r_state == ST_DONE);
    assign aborted = (r_state == ST_DONE) && r_aborted;

`ifdef RV_SOURCE_ASSERT_EN
    a_stall_hold: assert property (@(posedge CLK) disable iff (!ASYNCRESETN)
        (valid && !ready) |=> (valid && $stable(data) && $stable(last)));
    a_done_no_valid: assert property (@(posedge CLK) disable iff (!ASYNCRESETN)
        done |-> !valid);
    a_last_valid: assert property (@(posedge CLK) disable iff (!ASYNCRESETN)
        last |-> valid);
    a_busy_state: assert property (@(posedge CLK) disable iff (!ASYNCRESETN)
        busy == (r_state == ST_SEND));
`endif

endmodule

// File: tb/tb_rv_source.sv
// Scoreboard bench for rv_source: a default instance and a GAP=2/STEP=3 instance
// share stimulus; expected beats and done events are planned per burst from the rules.
module tb_rv_source;

    logic       CLK = 1'b0;
    logic       ASYNCRESETN;
    logic       start, abort, ready;
    logic [3:0] length, seed;
    logic [1:0] valid, last, busy, done, aborted;
    logic [3:0] data [2];

    int cyc = 0;
    int checks = 0;
    int failures = 0;
    bit rdy_tab [0:4095];

    typedef struct { int iv; logic [3:0] d; logic l; } beat_e;
    typedef struct { int iv; logic ab; } done_e;
    beat_e q_beat [2][$];
    done_e q_done [2][$];

    logic [1:0] prev_stall;
    logic [3:0] prev_data [2];
    logic [1:0] prev_last;

    rv_source u_dut0 (
        .CLK(CLK), .ASYNCRESETN(ASYNCRESETN), .start(start), .length(length),
        .seed(seed), .abort(abort), .ready(ready), .valid(valid[0]), .data(data[0]),
        .last(last[0]), .busy(busy[0]), .done(done[0]), .aborted(aborted[0])
    );

    rv_source #(.WIDTH(4), .LEN_W(4), .STEP(3), .GAP(2)) u_dut1 (
        .CLK(CLK), .ASYNCRESETN(ASYNCRESETN), .start(start), .length(length),
        .seed(seed), .abort(abort), .ready(ready), .valid(valid[1]), .data(data[1]),
        .last(last[1]), .busy(busy[1]), .done(done[1]), .aborted(aborted[1])
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at interval %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int idx, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s dut%0d: got %0d, expected %0d (interval %0d)", name, idx, act, exp, cyc);
        end
    endtask

    // Monitor: pop and compare on every handshake and done pulse.
    always @(negedge CLK) begin
        beat_e eb;
        done_e ed;
        if (ASYNCRESETN) begin
            for (int i = 0; i < 2; i++) begin
                if (prev_stall[i]) begin
                    chk("hold_valid", i, valid[i], 1);
                    chk("hold_data", i, data[i], prev_data[i]);
                    chk("hold_last", i, last[i], prev_last[i]);
                end
                if (valid[i] && ready) begin
                    if (q_beat[i].size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_beat dut%0d: got data %0d, expected no beat (interval %0d)", i, data[i], cyc);
                    end else begin
                        eb = q_beat[i].pop_front();
                        chk("beat_interval", i, cyc, eb.iv);
                        chk("beat_data", i, data[i], eb.d);
                        chk("beat_last", i, last[i], eb.l);
                        chk("beat_busy", i, busy[i], 1);
                    end
                end
                if (done[i]) begin
                    if (q_done[i].size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_done dut%0d: got done, expected none (interval %0d)", i, cyc);
                    end else begin
                        ed = q_done[i].pop_front();
                        chk("done_interval", i, cyc, ed.iv);
                        chk("done_aborted", i, aborted[i], ed.ab);
                        chk("done_valid", i, valid[i], 0);
                        chk("done_busy", i, busy[i], 0);
                    end
                end
                prev_stall[i] <= valid[i] && !ready;
                prev_data[i]  <= data[i];
                prev_last[i]  <= last[i];
            end
        end else begin
            prev_stall <= 2'b00;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
        ready = rdy_tab[cyc];
    endtask

    // Plan one burst for instance i from start interval s and abort interval a.
    task automatic plan(input int i, input int s, input int len, input logic [3:0] sd,
                        input int a, input bit push, output int d_iv);
        int c, h, gap, step;
        logic [3:0] dv;
        logic ab;
        bit fin;
        gap  = (i == 0) ? 0 : 2;
        step = (i == 0) ? 1 : 3;
        c = s + 1;
        dv = sd;
        fin = 1'b0;
        ab = 1'b0;
        d_iv = s + 1;
        for (int k = 0; k < len && !fin; k++) begin
            if (a >= 0 && a < c) begin
                d_iv = a + 1;
                ab = 1'b1;
                fin = 1'b1;
            end else begin
                h = c;
                while (h < 4095 && !rdy_tab[h]) h++;
                if (push) q_beat[i].push_back('{h, dv, logic'(k == len - 1)});
                if (k == len - 1) begin
                    d_iv = h + 1;
                    ab = 1'b0;
                    fin = 1'b1;
                end else if (a >= c && a <= h) begin
                    d_iv = h + 1;
                    ab = 1'b1;
                    fin = 1'b1;
                end
                dv = dv + 4'(step);
                c = h + 1 + gap;
            end
        end
        if (push) q_done[i].push_back('{d_iv, ab});
    endtask

    // mode 0 ready always, 1 random, 2 mostly ready, 3 table preset by caller;
    // a_rel -1 random abort, -2 none, >=0 abort at start interval + a_rel.
    task automatic run_burst(input int len, input logic [3:0] sd, input int mode, input int a_rel);
        int s, d0, d1, dmin, dmax, a;
        s = cyc;
        if (mode != 3) begin
            for (int j = s; j < s + 256 && j < 4096; j++) begin
                case (mode)
                    0: rdy_tab[j] = 1'b1;
                    1: rdy_tab[j] = ($urandom % 2 == 1) || (j % 8 == 7);
                    default: rdy_tab[j] = ($urandom % 4 != 0) || (j % 8 == 7);
                endcase
            end
        end
        plan(0, s, len, sd, -1, 1'b0, d0);
        plan(1, s, len, sd, -1, 1'b0, d1);
        dmin = (d0 < d1) ? d0 : d1;
        if (a_rel == -1) a = (dmin - 1 >= s + 1) ? int'($urandom_range(dmin - 1, s + 1)) : -1;
        else if (a_rel >= 0) a = s + a_rel;
        else a = -1;
        plan(0, s, len, sd, a, 1'b1, d0);
        plan(1, s, len, sd, a, 1'b1, d1);
        dmin = (d0 < d1) ? d0 : d1;
        dmax = (d0 > d1) ? d0 : d1;
        start = 1'b1;
        length = 4'(len);
        seed = sd;
        abort = 1'b0;
        ready = rdy_tab[s];
        while (cyc <= dmax) begin
            tick();
            start  = (cyc <= dmin) ? 1'($urandom % 2) : 1'b0;
            length = 4'($urandom);
            seed   = 4'($urandom);
            abort  = (cyc == a);
        end
    endtask

    initial begin
        ASYNCRESETN = 1'b1;
        start = 1'b0; abort = 1'b0; ready = 1'b0;
        length = 4'h0; seed = 4'h0;
        prev_stall = 2'b00;
        for (int j = 0; j < 4096; j++) rdy_tab[j] = 1'b1;
        #1 ASYNCRESETN = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("reset_valid", i, valid[i], 0);
            chk("reset_last", i, last[i], 0);
            chk("reset_busy", i, busy[i], 0);
            chk("reset_done", i, done[i], 0);
            chk("reset_aborted", i, aborted[i], 0);
            chk("reset_data", i, data[i], 0);
        end
        tick();
        tick();
        ASYNCRESETN = 1'b1;

        run_burst(3, 4'hE, 0, -2);
        run_burst(0, 4'h5, 0, -2);
        for (int j = cyc; j < cyc + 256; j++) rdy_tab[j] = 1'b1;
        for (int j = cyc + 1; j <= cyc + 3; j++) rdy_tab[j] = 1'b0;
        run_burst(2, 4'h7, 3, -2);
        run_burst(2, 4'hB, 0, -2);
        for (int j = cyc; j < cyc + 256; j++) rdy_tab[j] = 1'b1;
        for (int j = cyc + 2; j <= cyc + 4; j++) rdy_tab[j] = 1'b0;
        run_burst(5, 4'h3, 3, 2);
        run_burst(4, 4'hD, 0, 2);

        for (int n = 0; n < 30; n++) begin
            run_burst(int'($urandom_range(15, 0)), 4'($urandom), int'($urandom_range(2, 0)),
                      ($urandom % 3 == 0) ? -1 : -2);
        end

        for (int j = cyc; j < cyc + 8; j++) rdy_tab[j] = 1'b0;
        start = 1'b1; length = 4'd4; seed = 4'h9; ready = 1'b0;
        tick();
        start = 1'b0;
        #1;
        chk("pre_reset_valid", 0, valid[0], 1);
        chk("pre_reset_valid", 1, valid[1], 1);
        ASYNCRESETN = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("async_reset_valid", i, valid[i], 0);
            chk("async_reset_busy", i, busy[i], 0);
            chk("async_reset_data", i, data[i], 0);
        end
        tick();
        tick();
        for (int j = cyc; j < cyc + 256; j++) rdy_tab[j] = 1'b1;
        ASYNCRESETN = 1'b1;
        ready = 1'b1;
        for (int n = 0; n < 4; n++) tick();
        run_burst(4, 4'hA, 1, -2);

        for (int n = 0; n < 4; n++) tick();
        for (int i = 0; i < 2; i++) begin
            chk("beats_outstanding", i, q_beat[i].size(), 0);
            chk("dones_outstanding", i, q_done[i].size(), 0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
